// File: rtl/fsm_stim_sequencer.sv
// rtl/fsm_stim_sequencer.sv - drives a serial sequence-detector FSM from a latched parallel pattern
// Steps one bit per TICK_DIV-cycle window, records det_z per step and counts hits.
module fsm_stim_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned MAXLEN   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  len,
  input  logic [15:0] pattern,
  input  logic        det_z,
  output logic        det_x,
  output logic        det_en,
  output logic        det_rst,
  output logic        busy,
  output logic        done,
  output logic [4:0]  hit_count,
  output logic [15:0] z_trace
);

  localparam int unsigned    CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [4:0]     MAXLEN_W = 5'(MAXLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  k_q, k_d;
  logic [4:0]  len_q, len_d;
  logic [15:0] pat_q, pat_d;
  logic [4:0]  hit_q, hit_d;
  logic [15:0] trace_q, trace_d;

  logic       step;
  logic       last_bit;
  logic [3:0] bit_idx;

  // pattern[len-1] goes out first, so the bit index runs downward as k rises
  assign bit_idx  = 4'(len_q - 5'd1 - {1'b0, k_q});
  assign step     = (state_q == S_RUN) && (cnt_q == CNT_MAX);
  assign last_bit = (({1'b0, k_q} + 5'd1) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      hit_q   <= '0;
      trace_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      hit_q   <= hit_d;
      trace_q <= trace_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    len_d   = len_q;
    pat_d   = pat_q;
    hit_d   = hit_q;
    trace_d = trace_q;
    det_x   = 1'b0;
    det_en  = 1'b0;
    det_rst = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          len_d   = (len > MAXLEN_W) ? MAXLEN_W : len;
          pat_d   = pattern;
          hit_d   = '0;
          trace_d = '0;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        det_rst = 1'b1;
        busy    = 1'b1;
        if (abort)              state_d = S_IDLE;
        else if (len_q == 5'd0) state_d = S_DONE;
        else                    state_d = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        det_x  = pat_q[bit_idx];
        det_en = step;
        // abort wins over a coincident step: nothing is recorded
        if (abort) begin
          state_d = S_IDLE;
        end else if (step) begin
          trace_d[k_q] = det_z;
          hit_d        = hit_q + {4'b0, det_z};
          cnt_d        = '0;
          if (last_bit) state_d = S_DONE;
          else          k_d     = k_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hit_count = hit_q;
  assign z_trace   = trace_q;

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// tb/tb_fsm_stim_sequencer.sv - self-checking bench for fsm_stim_sequencer at TICK_DIV=4 and TICK_DIV=1
module tb_fsm_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  len = '0;
  logic [15:0] pattern = '0;
  bit          ztie = 1'b0;
  bit          zkey = 1'b0;

  logic a_x, a_en, a_rst, a_busy, a_done, a_z;
  logic [4:0]  a_hit;
  logic [15:0] a_tr;
  logic b_x, b_en, b_rst, b_busy, b_done, b_z;
  logic [4:0]  b_hit;
  logic [15:0] b_tr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // detector stand-in: loopback (optionally inverted) or tied high
  assign a_z = ztie ? 1'b1 : (a_x ^ zkey);
  assign b_z = ztie ? 1'b1 : (b_x ^ zkey);

  fsm_stim_sequencer #(.TICK_DIV(4), .MAXLEN(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .pattern(pattern), .det_z(a_z), .det_x(a_x), .det_en(a_en),
    .det_rst(a_rst), .busy(a_busy), .done(a_done), .hit_count(a_hit),
    .z_trace(a_tr)
  );

  fsm_stim_sequencer #(.TICK_DIV(1), .MAXLEN(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .pattern(pattern), .det_z(b_z), .det_x(b_x), .det_en(b_en),
    .det_rst(b_rst), .busy(b_busy), .done(b_done), .hit_count(b_hit),
    .z_trace(b_tr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // expected {det_rst, det_en, done, busy, det_x} in cycle c after the accepting edge
  function automatic logic [4:0] exp_out(int td, int L, logic [15:0] pat, int c, int ab);
    int last;
    logic [4:0] r;
    last = L * td;
    r = '0;
    if (ab >= 0 && ab <= last && c > ab) return r;
    if (c == 0) begin
      r = 5'b10010;
    end else if (c <= last) begin
      r[1] = 1'b1;
      r[0] = pat[L - 1 - (c - 1) / td];
      r[3] = ((c % td) == 0);
    end else if (c == last + 1) begin
      r[2] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [20:0] exp_res(int td, int L, logic [15:0] pat, bit zt, bit zk, int ab);
    logic [15:0] tr;
    int hits;
    logic zb;
    tr = '0;
    hits = 0;
    for (int k = 0; k < L; k++) begin
      if (ab >= 0 && ab <= (k + 1) * td) break;
      zb = zt ? 1'b1 : (pat[L - 1 - k] ^ zk);
      tr[k] = zb;
      hits += int'(zb);
    end
    return {5'(hits), tr};
  endfunction

  task automatic run_check(input int lenv, input logic [15:0] pat, input bit zt, input bit zk,
                           input int ab, input int st1, input int st2);
    int L;
    int ncyc;
    L = (lenv > 16) ? 16 : lenv;
    ncyc = L * 4 + 4;
    @(negedge clk);
    len = 5'(lenv);
    pattern = pat;
    ztie = zt;
    zkey = zk;
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check($sformatf("outA c=%0d", c), 32'({a_rst, a_en, a_done, a_busy, a_x}), 32'(exp_out(4, L, pat, c, ab)));
      check($sformatf("outB c=%0d", c), 32'({b_rst, b_en, b_done, b_busy, b_x}), 32'(exp_out(1, L, pat, c, ab)));
      start = (c == st1) || (c == st2);
      abort = (c == ab);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("resA", 32'({a_hit, a_tr}), 32'(exp_res(4, L, pat, zt, zk, ab)));
    check("resB", 32'({b_hit, b_tr}), 32'(exp_res(1, L, pat, zt, zk, ab)));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset outA", 32'({a_x, a_en, a_rst, a_busy, a_done, a_hit, a_tr}), 32'd0);
    check("reset outB", 32'({b_x, b_en, b_rst, b_busy, b_done, b_hit, b_tr}), 32'd0);
    rst_n = 1'b1;

    run_check(4, 16'h000D, 1'b0, 1'b0, -1, -1, -1);
    check("plan1 traceA", 32'(a_tr), 32'h000B);
    check("plan1 hitsA", 32'(a_hit), 32'd3);

    run_check(20, 16'h5A3C, 1'b1, 1'b0, -1, -1, -1);
    check("clamp traceB", 32'(b_tr), 32'hFFFF);
    check("clamp hitsB", 32'(b_hit), 32'd16);

    run_check(0, 16'hFFFF, 1'b1, 1'b0, -1, -1, -1);
    check("len0 hitsA", 32'(a_hit), 32'd0);

    run_check(8, 16'h00C7, 1'b1, 1'b0, 10, -1, -1);
    check("abort traceA", 32'(a_tr), 32'h0003);
    check("abort hitsA", 32'(a_hit), 32'd2);

    // start pulses while A runs, and while B is in RUN then in DONE
    run_check(16, 16'hB2E9, 1'b0, 1'b1, -1, 5, 17);

    // held start with len=0: CLEAR, DONE, IDLE repeating
    @(negedge clk);
    len = 5'd0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("hold A c=%0d", c), 32'({a_rst, a_done}), 32'({c % 3 == 0, c % 3 == 1}));
      check($sformatf("hold B c=%0d", c), 32'({b_rst, b_done}), 32'({c % 3 == 0, c % 3 == 1}));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of RUN
    len = 5'd16;
    pattern = 16'hFFFF;
    ztie = 1'b0;
    zkey = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", 32'({a_busy, b_busy}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async rst A", 32'({a_x, a_en, a_rst, a_busy, a_done, a_hit, a_tr}), 32'd0);
    check("async rst B", 32'({b_x, b_en, b_rst, b_busy, b_done, b_hit, b_tr}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset idle", 32'({a_busy, a_rst, a_done, b_busy, b_rst, b_done}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      int lv;
      int ab;
      lv = int'($urandom_range(0, 20));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : -1;
      run_check(lv, 16'($urandom), 1'($urandom), 1'($urandom), ab, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
